// File: rtl/shift_add_datapath_if.sv
// Bus bundle between the shift-add sequencer/board side and the multiplier datapath.
interface shift_add_datapath_if #(parameter int n = 8);
  logic [n-1:0]   din;
  logic           load_m;
  logic           load_q;
  logic           reset;
  logic           shift;
  logic           add_shift;
  logic           rd_hi;
  logic           Q0;
  logic           done;
  logic [2*n-1:0] product;
  logic [n-1:0]   dout;

  modport master (
    output din, load_m, load_q, reset, shift, add_shift, rd_hi,
    input  Q0, done, product, dout
  );

  modport slave (
    input  din, load_m, load_q, reset, shift, add_shift, rd_hi,
    output Q0, done, product, dout
  );
endinterface

// File: rtl/shift_add_datapath.sv
// Shift-add multiplier datapath: M, Qin staging, {A,Q} accumulator and step counter.
// Returns Q[0] to the sequencer and saturates after n steps.
module shift_add_datapath #(
  parameter int n = 8
) (
  input  logic                 clock,
  input  logic                 n_reset,
  shift_add_datapath_if.slave  bus
);
  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] N_STEPS = CW'(n);

  logic [n-1:0]  m_q, m_d;
  logic [n-1:0]  qin_q, qin_d;
  logic [n-1:0]  a_q, a_d;
  logic [n-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n:0]    sum;

  assign sum = {1'b0, a_q} + {1'b0, m_q};

  always_comb begin
    m_d   = m_q;
    qin_d = qin_q;
    a_d   = a_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    if (bus.load_m) m_d = bus.din;
    if (bus.load_q) qin_d = bus.din;
    if (bus.reset) begin
      a_d   = '0;
      cnt_d = '0;
      // Bypass lets a same-cycle Q load and restart share one clock.
      q_d   = bus.load_q ? bus.din : qin_q;
    end else if (cnt_q != N_STEPS) begin
      if (bus.add_shift) begin
        a_d   = sum[n:1];
        q_d   = {sum[0], q_q[n-1:1]};
        cnt_d = cnt_q + 1'b1;
      end else if (bus.shift) begin
        a_d   = {1'b0, a_q[n-1:1]};
        q_d   = {a_q[0], q_q[n-1:1]};
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      m_q   <= '0;
      qin_q <= '0;
      a_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      qin_q <= qin_d;
      a_q   <= a_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.Q0      = q_q[0];
  assign bus.done    = (cnt_q == N_STEPS);
  assign bus.product = {a_q, q_q};
  assign bus.dout    = bus.rd_hi ? a_q : q_q;
endmodule

// File: tb/tb_shift_add_datapath.sv
// Scoreboard bench for shift_add_datapath: stimulus queues expectations, monitor checks at negedge.
module tb_shift_add_datapath;
  localparam int N = 8;

  logic clock;
  logic n_reset;

  shift_add_datapath_if #(.n(N)) bus ();

  shift_add_datapath #(.n(N)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int { K_PROD, K_DONE, K_Q0, K_DOUT } kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  // Monitor: everything queued since the last negedge is checked against stable outputs.
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_PROD:  act = bus.product;
        K_DONE:  act = {15'd0, bus.done};
        K_Q0:    act = {15'd0, bus.Q0};
        default: act = {8'd0, bus.dout};
      endcase
      tests++;
      if (act !== e.val) begin
        failed++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic expect_v(input kind_e k, input logic [15:0] v, input string nm);
    exp_t e;
    e.kind = k; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic hold();
    @(posedge clock); #1;
  endtask

  task automatic clr();
    bus.load_m = 0; bus.load_q = 0; bus.reset = 0;
    bus.shift = 0; bus.add_shift = 0;
  endtask

  task automatic step(input logic add, input logic sh);
    bus.add_shift = add; bus.shift = sh;
    hold();
    clr();
  endtask

  task automatic load(input logic [7:0] m, input logic [7:0] q);
    bus.din = m; bus.load_m = 1; hold(); clr();
    bus.din = q; bus.load_q = 1; hold(); clr();
  endtask

  task automatic start();
    bus.reset = 1; hold(); clr();
  endtask

  // Multiplier bits decide each step; Q0 must present the same bit beforehand.
  task automatic run_steps(input logic [7:0] q, input int unsigned first, input int unsigned last,
                           input string nm);
    for (int unsigned i = first; i < last; i++) begin
      expect_v(K_Q0, {15'd0, q[i]}, nm);
      step(q[i], !q[i]);
    end
  endtask

  initial begin
    n_reset = 0; bus.rd_hi = 0; bus.din = '0; clr();
    hold(); hold();
    expect_v(K_PROD, 16'h0000, "reset_product");
    expect_v(K_DONE, 16'h0000, "reset_done");
    expect_v(K_Q0,   16'h0000, "reset_q0");
    expect_v(K_DOUT, 16'h0000, "reset_dout");
    hold();
    n_reset = 1;
    hold();

    // 13 * 11
    load(8'h0D, 8'h0B);
    start();
    expect_v(K_PROD, 16'h000B, "basic_start");
    expect_v(K_DONE, 16'h0000, "basic_notdone");
    run_steps(8'h0B, 0, 8, "basic_q0");
    tests++;
    if (bus.product !== 16'h008F) begin
      failed++;
      $display("FAIL basic_product_direct: got %h expected 008f", bus.product);
    end
    tests++;
    if (bus.done !== 1'b1) begin
      failed++;
      $display("FAIL basic_done_direct: got %b expected 1", bus.done);
    end
    expect_v(K_PROD, 16'h008F, "basic_product");
    expect_v(K_DONE, 16'h0001, "basic_done");
    bus.rd_hi = 1;
    expect_v(K_DOUT, 16'h0000, "basic_dout_hi");
    hold();
    bus.rd_hi = 0;
    expect_v(K_DOUT, 16'h008F, "basic_dout_lo");
    hold();

    // Overrun after done
    for (int unsigned i = 0; i < 3; i++) step(1, 0);
    expect_v(K_PROD, 16'h008F, "overrun_product");
    expect_v(K_DONE, 16'h0001, "overrun_done");
    hold();

    // 255 * 255, carry lands in A[7]
    load(8'hFF, 8'hFF);
    start();
    step(1, 0);
    expect_v(K_PROD, 16'h7FFF, "max_step1");
    run_steps(8'hFF, 1, 8, "max_q0");
    tests++;
    if (bus.product !== 16'hFE01) begin
      failed++;
      $display("FAIL max_product_direct: got %h expected fe01", bus.product);
    end
    expect_v(K_PROD, 16'hFE01, "max_product");
    expect_v(K_DONE, 16'h0001, "max_done");
    hold();

    // shift and add_shift together: add_shift wins
    load(8'h01, 8'h00);
    start();
    step(1, 1);
    expect_v(K_PROD, 16'h0080, "priority_product");
    hold();

    // Restart mid-operation
    load(8'h0D, 8'h0B);
    start();
    run_steps(8'h0B, 0, 4, "restart_q0");
    start();
    expect_v(K_PROD, 16'h000B, "restart_cleared");
    expect_v(K_DONE, 16'h0000, "restart_notdone");
    run_steps(8'h0B, 0, 8, "rerun_q0");
    tests++;
    if (bus.product !== 16'h008F) begin
      failed++;
      $display("FAIL rerun_product_direct: got %h expected 008f", bus.product);
    end
    expect_v(K_PROD, 16'h008F, "rerun_product");
    hold();

    // load_q bypass on reset
    bus.din = 8'h05; bus.load_q = 1; bus.reset = 1;
    hold(); clr();
    tests++;
    if (bus.product !== 16'h0005) begin
      failed++;
      $display("FAIL bypass_product_direct: got %h expected 0005", bus.product);
    end
    expect_v(K_PROD, 16'h0005, "bypass_product");
    hold();

    // Async reset mid-operation
    load(8'h0D, 8'h0B);
    start();
    run_steps(8'h0B, 0, 3, "async_q0");
    #1 n_reset = 0;
    expect_v(K_PROD, 16'h0000, "async_product");
    expect_v(K_Q0,   16'h0000, "async_q0_zero");
    expect_v(K_DONE, 16'h0000, "async_done");
    hold();
    n_reset = 1;
    hold();
    start();
    run_steps(8'h00, 0, 8, "postreset_q0");
    expect_v(K_PROD, 16'h0000, "postreset_product");
    expect_v(K_DONE, 16'h0001, "postreset_done");
    hold();
    hold();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/shift_add_datapath.md
Name: shift_add_datapath

Overview:
- Datapath responder for the shift-add multiplier sequencer. It consumes the sequencer's `reset`, `shift` and `add_shift` strobes and returns the multiplier LSB (`Q0`) that the sequencer uses to choose its next step.
- It holds the multiplicand M, a multiplier staging register Qin, and the accumulator pair {A,Q}.
- Operands load byte-wise from the board data bus.
- The 2n-bit product is read back either whole or one half at a time, selected by `rd_hi`.

Parameters:
- n, 8, operand width in bits; product width is 2n. Legal range 2..16.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- n_reset  input  1  asynchronous active-low reset, clears all state.
- din  input  n  operand data from the bus.
- load_m  input  1  when high, M <= din.
- load_q  input  1  when high, Qin <= din.
- reset  input  1  synchronous strobe from the sequencer; starts a new multiplication.
- shift  input  1  sequencer strobe: shift {A,Q} right by one.
- add_shift  input  1  sequencer strobe: A += M, then shift right by one.
- Q0  output  1  Q[0], returned to the sequencer.
- done  output  1  high once n shift steps have completed since the last `reset`.
- product  output  2n  {A,Q}.
- rd_hi  input  1  readout select.
- dout  output  n  A when rd_hi=1, otherwise Q (combinational).

Behaviour:
- Async reset (n_reset=0): M, Qin, A, Q and step counter cnt all go to 0 immediately. Resulting outputs: Q0=0, done=0, product=0, dout=0.
- State registers:
  - M[n-1:0], Qin[n-1:0], A[n-1:0], Q[n-1:0].
  - cnt, width clog2(n+1), range 0..n.
- Loads: `load_m` and `load_q` are independent of each other and of the strobes, and are honoured in any cycle, including mid-multiplication. Loading M mid-operation affects subsequent `add_shift` steps.
- Strobe priority, per cycle: reset > add_shift > shift. If `shift` and `add_shift` are both high, only `add_shift` acts.
- reset (sync) strobe:
  - A <= 0, cnt <= 0.
  - Q <= Qin. If `load_q` is high in the same cycle, Q <= din (bypass), so load and start can share one cycle.
- add_shift, when cnt<n:
  - sum[n:0] = {1'b0,A} + M.
  - A <= sum[n:1], Q <= {sum[0], Q[n-1:1]}, cnt <= cnt+1.
  - The carry is absorbed into A[n-1]; no separate carry register exists.
- shift, when cnt<n: A <= {1'b0, A[n-1:1]}, Q <= {A[0], Q[n-1:1]}, cnt <= cnt+1.
- Saturation: when cnt==n, `shift` and `add_shift` are ignored (A, Q, cnt hold). This protects the finished product from an overrunning sequencer.
- Outputs:
  - done = (cnt==n), registered-state decode.
  - Q0 = Q[0], valid the cycle after the update.
  - product = {A,Q}. After n steps, product = M*Q_initial exactly, with no overflow (the max (2^n-1)^2 fits in 2n bits).
- Latency: one clock from strobe to updated Q0/product/done. The sequencer samples Q0 at its next step.
- `reset` mid-operation: the multiplication is discarded and restarts from Qin. M is retained.
- Release of n_reset is synchronous to clock at system level; no internal synchronizer is required.

Test Plan:
- Basic multiply: n_reset pulse; load_m with din=8'h0D; load_q with din=8'h0B; reset strobe; then 8 steps, each add_shift if Q0=1 else shift -> done=1 after the 8th step, product=16'h008F, dout=8'h00 with rd_hi=1 and 8'h8F with rd_hi=0.
- Max operands: M=8'hFF, Qin=8'hFF, same stepping -> product=16'hFE01. Verify the add carry lands in A[7] on every add_shift (A after step 1 = 8'h7F, Q=8'hFF).
- Overrun and priority:
  - After done, issue 3 extra add_shift -> product unchanged, done stays 1.
  - Mid-operation, assert shift and add_shift together with M=1 -> A updated as add_shift.
- Restart and bypass:
  - Assert reset at step 4 of 13*11 -> A=0, Q=8'h0B, done=0; re-run gives 16'h008F.
  - load_q with din=8'h05 in the same cycle as reset -> Q=8'h05 next cycle.
- Async reset mid-op: drop n_reset at step 3, between clock edges -> product, Q0, done read 0 before the next edge. M and Qin read 0 after release (a multiply without reloads gives product 0).
